// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants and issue-side decode shared by the pipeline stages.
package mips_isa_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;
    localparam int INSTR_W = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] F_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] F_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] F_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] F_SLLV = 6'h04;
    localparam logic [FUNCT_W-1:0] F_SRLV = 6'h06;
    localparam logic [FUNCT_W-1:0] F_SRAV = 6'h07;
    localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic             dest_en;
        logic [REG_W-1:0] dest;
        logic             rt_src;
    } dec_t;

    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        logic [OP_W-1:0]    op;
        logic [FUNCT_W-1:0] funct;
        logic               r_wr;
        logic               i_wr;
        dec_t               d;
        op    = instr[31:26];
        funct = instr[5:0];
        r_wr  = (op == OP_RTYPE) && (funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                 F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU});
        i_wr  = op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW};
        d.dest_en = r_wr || i_wr;
        d.dest    = r_wr ? instr[15:11] : instr[20:16];
        d.rt_src  = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
        return d;
    endfunction

endpackage

// File: rtl/gpr_file.sv
// gpr_file: general-purpose register file, two async read ports, one sync write port, r0 hard-wired 0.
module gpr_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: decodes rs/rt, reads the GPR file, stalls on scoreboard hazards and
// presents a registered {instruction, reg_A, reg_B} bundle to the ALU under valid/ready.
module operand_issue_stage
    import mips_isa_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [DATA_W-1:0]  out_reg_A,
    output logic [DATA_W-1:0]  out_reg_B,
    output logic               out_dest_en,
    output logic [REG_W-1:0]   out_dest,
    input  logic               wb_en,
    input  logic [REG_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]  wb_data
);

    logic [REG_W-1:0]    rs, rt;
    dec_t                dec;
    logic [DATA_W-1:0]   rd_a, rd_b;
    logic                fwd_a, fwd_b, hazard, issue;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                valid_q, dest_en_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [REG_W-1:0]    dest_q;

    // A pending register stops blocking in the cycle its write-back arrives only when bypassing.
    function automatic logic busy(input logic [REG_W-1:0] r);
        return pending_q[r] && !(WB_BYPASS && wb_en && wb_addr == r);
    endfunction

    assign rs  = in_instr[25:21];
    assign rt  = in_instr[20:16];
    assign dec = decode(in_instr);

    assign hazard   = busy(rs) || (dec.rt_src && busy(rt)) || (dec.dest_en && busy(dec.dest));
    assign in_ready = !hazard && (!valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    assign fwd_a = WB_BYPASS && wb_en && wb_addr == rs && rs != '0;
    assign fwd_b = WB_BYPASS && wb_en && wb_addr == rt && rt != '0;

    gpr_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(REG_W)) u_gpr (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs),
        .rdata_a_o (rd_a),
        .raddr_b_i (rt),
        .rdata_b_o (rd_b)
    );

    // Write-back clears first so that a same-cycle re-issue to that register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) pending_d[wb_addr] = 1'b0;
        if (issue && dec.dest_en && dec.dest != '0) pending_d[dec.dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dest_en_q <= 1'b0;
            dest_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (issue) begin
                valid_q   <= 1'b1;
                instr_q   <= in_instr;
                a_q       <= fwd_a ? wb_data : rd_a;
                b_q       <= fwd_b ? wb_data : rd_b;
                dest_en_q <= dec.dest_en;
                dest_q    <= dec.dest;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_instruction = instr_q;
    assign out_reg_A       = a_q;
    assign out_reg_B       = b_q;
    assign out_dest_en     = dest_en_q;
    assign out_dest        = dest_q;

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Operand-fetch and issue stage directly upstream of the combinational ALU (`alu(instruction, reg_A, reg_B, result, flags)`).
- Holds the 32-entry GPR file and decodes rs/rt.
- Tracks outstanding writes with a scoreboard and stalls on hazards.
- Presents a registered {instruction, reg_A, reg_B} bundle to the ALU under valid/ready, and accepts write-backs from downstream.

Parameters:
- DATA_W, 32, GPR and operand width.
- NUM_REGS, 32, GPR count; address width is 5.
- WB_BYPASS, 1, when 1, a same-cycle write-back is forwarded into operand read and the hazard check.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  MIPS instruction word.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- out_instruction  out  32  instruction to ALU `instruction` input.
- out_reg_A  out  DATA_W  GPR[rs], drives ALU reg_A.
- out_reg_B  out  DATA_W  GPR[rt], drives ALU reg_B.
- out_dest_en  out  1  instruction writes a GPR.
- out_dest  out  5  destination register.
- wb_en  in  1  write-back strobe from downstream.
- wb_addr  in  5  write-back register.
- wb_data  in  DATA_W  write-back value.

Behaviour:
- Reset: GPRs, pending[31:0], out_valid, out_instruction, out_reg_A, out_reg_B, out_dest_en and out_dest all go to 0 immediately. Any in-flight bundle is dropped. The outputs are held at 0 until the first issue after reset deassertion.
- Field decode: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- R-type writers: op=0 with funct in {20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07}h. dest=rd.
- I-type writers: op in {08,09,0C,0D,0E,0A,0B,23}h. dest=rt.
- Non-writers: beq 04h, bne 05h, sw 2Bh, and any undecoded op/funct. These pass through with dest_en=0.
- Sources: rs is always a source. rt is a source only for op=0, 04h, 05h and 2Bh.
- Register 0: always reads 0, is never marked pending, and ignores write-backs.
- Hazard: a used source, or the dest when dest_en=1, is pending and is not cleared by wb_en this cycle (the clear counts only when WB_BYPASS=1).
- in_ready = !hazard && (!out_valid || out_ready). Issue = in_valid && in_ready.
- in_ready may depend combinationally on in_instr. It never depends on in_valid.
- On issue:
  - Output registers load next edge: out_valid=1.
  - Operands = GPR[src], or wb_data when WB_BYPASS=1 && wb_en && wb_addr==src && src!=0.
- If out_ready && !issue, out_valid falls to 0. The bundle holds stable while out_valid && !out_ready.
- Latency: 1 cycle from accepted in_instr to out_valid.
- Scoreboard update per edge:
  - First, wb_en clears pending[wb_addr] and writes the GPR.
  - Then issue with dest_en && dest!=0 sets pending[dest].
  - Same-register clear and set in one cycle: set wins.
- The WAW stall guarantees at most one outstanding write per register, so write-backs cannot retire out of order.
- wb_en to a non-pending register: GPR is written, no error.
- Back-to-back: a dependent instruction issues in the same cycle its producer's write-back arrives (WB_BYPASS=1), or one cycle later (WB_BYPASS=0).

Decomposition:
- Shared package `mips_isa_pkg`:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE, OP_LW, OP_SW);
  - funct constants;
  - field-slice widths.
  - The ALU and later stages use the same package.
- One sub-module, `gpr_file`: NUM_REGS x DATA_W, two async read ports, one sync write port, r0 hard-wired 0, async reset clear.
- Decode and the scoreboard stay in the top.

Test Plan:
- Reset mid-issue: assert reset while out_valid=1 -> out_valid=0 and all outputs 0 within the same cycle. After release, GPR[5] reads 0.
- Write-back then read: wb $1=000000FFh, $2=00000001h. Issue add $3,$1,$2 (00221820h) -> next cycle out_reg_A=FFh, out_reg_B=01h, out_dest=3, out_dest_en=1.
- RAW stall: issue add $3 (pending[3]=1), then sub $4,$3,$1 -> in_ready=0 until wb_en with wb_addr=3, wb_data=100h. With WB_BYPASS=1, it issues that cycle with out_reg_A=100h.
- Non-writer/rt usage:
  - beq $1,$2 (10220000h) -> dest_en=0, no pending set.
  - addi $2,$1,... with $2 pending -> stalls (WAW).
  - addi $5,$1,... with only $5's rt... not a source; $1 not pending -> issues.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the bundle is held bit-stable. Raising out_ready issues the next instruction on that edge.
- Register 0: wb_en to $0 with FFFFFFFFh, then issue or $1,$0,$0 -> out_reg_A=out_reg_B=0, no stall.
